reg_file_sb: RTL and testbench
==============================

Name: reg_file_sb

Overview:
- Parametrised successor to the single-cycle 3-port register file: 2 combinational read ports, 1 synchronous write port.
- Adds asynchronous clear, optional write-to-read bypass, and an integrated per-register busy scoreboard for a pipelined core.
- Sits between decode (read and issue), writeback (write), and hazard control (busy flags, issue grant).

Parameters:
- XLEN, 32, data width in bits (>= 8).
- NREGS, 32, number of architectural registers (power of 2, >= 2).
- AW, $clog2(NREGS), address width (derived localparam, not overridable).
- BYPASS, 1, when 1 a same-cycle write is forwarded to the read ports and busy flags.

Ports:
- clk  in  1  clock, all state updates on the rising edge
- rst_n  in  1  asynchronous active-low reset
- we3  in  1  writeback write enable
- wa3  in  AW  writeback address
- wd3  in  XLEN  writeback data
- ra1  in  AW  read address 1
- ra2  in  AW  read address 2
- rd1  out  XLEN  read data 1
- rd2  out  XLEN  read data 2
- busy1  out  1  register ra1 has an outstanding producer
- busy2  out  1  register ra2 has an outstanding producer
- iss_valid  in  1  decode requests to issue an instruction writing iss_rd
- iss_rd  in  AW  destination of the issuing instruction
- iss_ok  out  1  issue granted this cycle

Behaviour:
- Interface: one clock, clk; reset is asynchronous and active-low, rst_n. Polarity and synchronicity are fixed.
- Reset (rst_n=0, asynchronous): all NREGS entries clear to 0 and all busy bits clear to 0.
- Reset outputs (combinational from cleared state): rd1=rd2=0, busy1=busy2=0, iss_ok=iss_valid.
- Reset asserted mid-operation discards all pending writes and issues. A write in the same edge as reset release is not performed.
- Register 0 is hardwired zero:
  - A write to address 0 is ignored.
  - A read of address 0 returns 0.
  - busy for address 0 is always 0.
  - Issue to iss_rd=0 always grants and sets no busy bit.
- Write: on the rising edge with we3=1 and wa3!=0, rf[wa3] <= wd3.
- Read, BYPASS=0: rdN = rf[raN] (value before the edge).
- Read, BYPASS=1: if we3 && wa3==raN && raN!=0, rdN=wd3; otherwise rf[raN].
- Read latency is 0 cycles (combinational). A written value is visible from the next cycle, or the same cycle when BYPASS=1.
- Scoreboard state: busy[NREGS-1:0], one bit per register.
- wb_clear = we3 && wa3!=0. On the edge this clears busy[wa3].
- iss_ok = iss_valid && (iss_rd==0 || !busy[iss_rd] || (BYPASS && wb_clear && wa3==iss_rd)).
  - iss_ok=0 means decode stalls. This enforces at most one outstanding producer per register, so no WAW tags are needed.
- On the edge, if iss_ok && iss_rd!=0, set busy[iss_rd].
- Set beats clear: a same-cycle issue and writeback to the same register leaves busy=1.
- busyN = busy[raN] && !(BYPASS && wb_clear && wa3==raN). The raN==0 case forces 0.
- A writeback to a non-busy register (e.g. initial load) writes data normally and leaves busy at 0.
- Address widths are exact, so there is no out-of-range case.

Decomposition:
- Package rf_pkg:
  - XLEN_DEF=32, NREGS_DEF=32.
  - Function addr_w(n) returning $clog2(n).
  - Constant ZERO_REG=0.
- Sub-module rf_scoreboard (params NREGS, BYPASS):
  - Holds the busy vector, the set/clear logic, iss_ok, and busy1/busy2.
- The top module keeps the storage array, write logic, and read/bypass muxes.

Test Plan:
- Reset then read all addresses -> rd1=rd2=0 and busy1=busy2=0 for every address; iss_valid=1 with iss_rd=5 -> iss_ok=1.
- we3=1, wa3=7, wd3=0xDEADBEEF, ra1=7 in the same cycle -> BYPASS=1: rd1=0xDEADBEEF immediately; BYPASS=0: rd1=0 that cycle, 0xDEADBEEF next cycle.
- we3=1, wa3=0, wd3=0x1234 -> next cycle ra1=0 gives rd1=0; issue to rd 0 twice in a row -> iss_ok=1 both times, busy stays 0.
- Issue rd=3, then next cycle issue rd=3 again -> second iss_ok=0 and busy1 (ra1=3) =1; writeback wa3=3 same cycle with BYPASS=1 -> iss_ok=1 and busy[3] remains 1 after the edge.
- Issue rd=9 and write wa3=9 wd3=0x55 in the same cycle with busy[9]=0 -> after the edge busy[9]=1 and rf[9]=0x55 (set beats clear).
- Write rf[4]=0xA5, set busy[4], pulse rst_n low between edges -> rd1 (ra1=4) drops to 0 and busy1=0 without a clock edge.

Source files
------------

// File: rtl/rf_pkg.sv
// rf_pkg: shared defaults and helpers for the scoreboarded register file.
`default_nettype none

package rf_pkg;

   localparam int XLEN_DEF  = 32;
   localparam int NREGS_DEF = 32;
   localparam int ZERO_REG  = 0;

   function automatic int addr_w(input int n);
      return $clog2(n);
   endfunction

endpackage

`default_nettype wire

// File: rtl/rf_scoreboard.sv
// rf_scoreboard: per-register busy bits, issue grant and busy flags for the read ports.
`default_nettype none

module rf_scoreboard
   import rf_pkg::*;
#(
   parameter  int NREGS  = NREGS_DEF,
   parameter  bit BYPASS = 1'b1,
   localparam int AW     = addr_w(NREGS)
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          i_we,
   input  logic [AW-1:0] i_wa,
   input  logic [AW-1:0] i_ra1,
   input  logic [AW-1:0] i_ra2,
   input  logic          i_iss_valid,
   input  logic [AW-1:0] i_iss_rd,
   output logic          o_busy1,
   output logic          o_busy2,
   output logic          o_iss_ok
);

   localparam logic [AW-1:0] ZERO_ADDR = AW'(ZERO_REG);

   logic [NREGS-1:0] r_busy;
   logic             w_wb_clear;
   logic [NREGS-1:0] w_clr_vec;
   logic [NREGS-1:0] w_set_vec;

   assign w_wb_clear = i_we && (i_wa != ZERO_ADDR);

   // A writeback landing this cycle already satisfies the hazard when forwarding is on.
   assign o_iss_ok = i_iss_valid &&
                     ((i_iss_rd == ZERO_ADDR) || !r_busy[i_iss_rd] ||
                      (BYPASS && w_wb_clear && (i_wa == i_iss_rd)));

   assign o_busy1 = (i_ra1 != ZERO_ADDR) && r_busy[i_ra1] &&
                    !(BYPASS && w_wb_clear && (i_wa == i_ra1));
   assign o_busy2 = (i_ra2 != ZERO_ADDR) && r_busy[i_ra2] &&
                    !(BYPASS && w_wb_clear && (i_wa == i_ra2));

   assign w_clr_vec = w_wb_clear ? (NREGS'(1) << i_wa) : '0;
   assign w_set_vec = (o_iss_ok && (i_iss_rd != ZERO_ADDR)) ? (NREGS'(1) << i_iss_rd) : '0;

   // Set is applied after clear so a same-cycle issue keeps the register busy.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_busy <= '0;
      end else begin
         r_busy <= (r_busy & ~w_clr_vec) | w_set_vec;
      end
   end

endmodule

`default_nettype wire

// File: rtl/reg_file_sb.sv
// reg_file_sb: 2R/1W register file with zero register, optional write bypass and busy scoreboard.
`default_nettype none

module reg_file_sb
   import rf_pkg::*;
#(
   parameter  int XLEN   = XLEN_DEF,
   parameter  int NREGS  = NREGS_DEF,
   parameter  bit BYPASS = 1'b1,
   localparam int AW     = addr_w(NREGS)
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            we3,
   input  logic [AW-1:0]   wa3,
   input  logic [XLEN-1:0] wd3,
   input  logic [AW-1:0]   ra1,
   input  logic [AW-1:0]   ra2,
   output logic [XLEN-1:0] rd1,
   output logic [XLEN-1:0] rd2,
   output logic            busy1,
   output logic            busy2,
   input  logic            iss_valid,
   input  logic [AW-1:0]   iss_rd,
   output logic            iss_ok
);

   localparam logic [AW-1:0] ZERO_ADDR = AW'(ZERO_REG);

   logic [XLEN-1:0] r_rf [NREGS];
   logic            w_we;
   logic            w_fwd1;
   logic            w_fwd2;

   assign w_we = we3 && (wa3 != ZERO_ADDR);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NREGS; i++) begin
            r_rf[i] <= '0;
         end
      end else if (w_we) begin
         r_rf[wa3] <= wd3;
      end
   end

   // w_we already excludes address 0, so forwarding never overrides the zero register.
   assign w_fwd1 = BYPASS && w_we && (wa3 == ra1);
   assign w_fwd2 = BYPASS && w_we && (wa3 == ra2);

   assign rd1 = (ra1 == ZERO_ADDR) ? '0 : (w_fwd1 ? wd3 : r_rf[ra1]);
   assign rd2 = (ra2 == ZERO_ADDR) ? '0 : (w_fwd2 ? wd3 : r_rf[ra2]);

   rf_scoreboard #(
      .NREGS  (NREGS),
      .BYPASS (BYPASS)
   ) u_sb (
      .clk         (clk),
      .rst_n       (rst_n),
      .i_we        (we3),
      .i_wa        (wa3),
      .i_ra1       (ra1),
      .i_ra2       (ra2),
      .i_iss_valid (iss_valid),
      .i_iss_rd    (iss_rd),
      .o_busy1     (busy1),
      .o_busy2     (busy2),
      .o_iss_ok    (iss_ok)
   );

endmodule

`default_nettype wire

// File: tb/tb_reg_file_sb.sv
// tb_reg_file_sb: directed and random checks of reg_file_sb, with and without bypass.
`default_nettype none

module tb_reg_file_sb;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        we3;
   logic [4:0]  wa3;
   logic [31:0] wd3;
   logic [4:0]  ra1;
   logic [4:0]  ra2;
   logic        iss_valid;
   logic [4:0]  iss_rd;

   logic [31:0] rd1_b, rd2_b, rd1_n, rd2_n;
   logic        busy1_b, busy2_b, ok_b, busy1_n, busy2_n, ok_n;

   int n_tests = 0;
   int n_fail  = 0;

   logic [31:0] m_rf   [32];
   bit          m_busy [2][32];

   always #5 clk = ~clk;

   reg_file_sb #(.XLEN(32), .NREGS(32), .BYPASS(1'b1)) dut_b (
      .clk(clk), .rst_n(rst_n), .we3(we3), .wa3(wa3), .wd3(wd3),
      .ra1(ra1), .ra2(ra2), .rd1(rd1_b), .rd2(rd2_b),
      .busy1(busy1_b), .busy2(busy2_b),
      .iss_valid(iss_valid), .iss_rd(iss_rd), .iss_ok(ok_b)
   );

   reg_file_sb #(.XLEN(32), .NREGS(32), .BYPASS(1'b0)) dut_n (
      .clk(clk), .rst_n(rst_n), .we3(we3), .wa3(wa3), .wd3(wd3),
      .ra1(ra1), .ra2(ra2), .rd1(rd1_n), .rd2(rd2_n),
      .busy1(busy1_n), .busy2(busy2_n),
      .iss_valid(iss_valid), .iss_rd(iss_rd), .iss_ok(ok_n)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Reference model: architectural state as arrays, rules applied directly.
   function automatic bit wb_hits(input logic [4:0] a);
      return we3 && (wa3 != 0) && (wa3 == a);
   endfunction

   function automatic logic [31:0] exp_rd(input int byp, input logic [4:0] a);
      if (a == 0) return 32'h0;
      if (byp == 1 && wb_hits(a)) return wd3;
      return m_rf[a];
   endfunction

   function automatic bit exp_busy(input int byp, input logic [4:0] a);
      if (a == 0) return 1'b0;
      if (byp == 1 && wb_hits(a)) return 1'b0;
      return m_busy[byp][a];
   endfunction

   function automatic bit exp_ok(input int byp);
      if (!iss_valid) return 1'b0;
      if (iss_rd == 0) return 1'b1;
      if (!m_busy[byp][iss_rd]) return 1'b1;
      return (byp == 1) && wb_hits(iss_rd);
   endfunction

   task automatic model_reset();
      for (int i = 0; i < 32; i++) begin
         m_rf[i] = 32'h0;
         m_busy[0][i] = 1'b0;
         m_busy[1][i] = 1'b0;
      end
   endtask

   task automatic drive(input logic we, input logic [4:0] wa, input logic [31:0] wd,
                        input logic [4:0] r1, input logic [4:0] r2,
                        input logic iv, input logic [4:0] ird);
      we3 = we; wa3 = wa; wd3 = wd; ra1 = r1; ra2 = r2; iss_valid = iv; iss_rd = ird;
   endtask

   task automatic check_all();
      check("rd1_byp",   rd1_b,   exp_rd(1, ra1));
      check("rd2_byp",   rd2_b,   exp_rd(1, ra2));
      check("busy1_byp", {31'b0, busy1_b}, {31'b0, exp_busy(1, ra1)});
      check("busy2_byp", {31'b0, busy2_b}, {31'b0, exp_busy(1, ra2)});
      check("isok_byp",  {31'b0, ok_b},    {31'b0, exp_ok(1)});
      check("rd1_nob",   rd1_n,   exp_rd(0, ra1));
      check("rd2_nob",   rd2_n,   exp_rd(0, ra2));
      check("busy1_nob", {31'b0, busy1_n}, {31'b0, exp_busy(0, ra1)});
      check("busy2_nob", {31'b0, busy2_n}, {31'b0, exp_busy(0, ra2)});
      check("isok_nob",  {31'b0, ok_n},    {31'b0, exp_ok(0)});
   endtask

   task automatic settle();
      #3;
      check_all();
   endtask

   // Advance one edge and apply the same edge to the model; ends 1 time unit after the edge.
   task automatic tick();
      bit ok1, ok0;
      @(posedge clk);
      ok1 = exp_ok(1);
      ok0 = exp_ok(0);
      if (we3 && wa3 != 0) begin
         m_rf[wa3]      = wd3;
         m_busy[0][wa3] = 1'b0;
         m_busy[1][wa3] = 1'b0;
      end
      if (ok1 && iss_rd != 0) m_busy[1][iss_rd] = 1'b1;
      if (ok0 && iss_rd != 0) m_busy[0][iss_rd] = 1'b1;
      #1;
   endtask

   initial begin
      rst_n = 1'b0;
      drive(1'b0, 5'd0, 32'h0, 5'd0, 5'd0, 1'b0, 5'd0);
      model_reset();
      #2;
      for (int a = 0; a < 32; a++) begin
         ra1 = 5'(a);
         ra2 = 5'(31 - a);
         #1;
         check("rst_rd1",   rd1_b | rd1_n, 32'h0);
         check("rst_rd2",   rd2_b | rd2_n, 32'h0);
         check("rst_busy",  {30'b0, busy1_b | busy1_n, busy2_b | busy2_n}, 32'h0);
      end
      iss_valid = 1'b1; iss_rd = 5'd5;
      #1;
      check("rst_isok", {30'b0, ok_b, ok_n}, 32'h3);
      iss_valid = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      // Same-cycle write and read of r7
      drive(1'b1, 5'd7, 32'hDEADBEEF, 5'd7, 5'd0, 1'b0, 5'd0);
      settle();
      check("byp_same", rd1_b, 32'hDEADBEEF);
      check("nob_same", rd1_n, 32'h0);
      tick();
      drive(1'b0, 5'd0, 32'h0, 5'd7, 5'd7, 1'b0, 5'd0);
      settle();
      check("nob_next", rd1_n, 32'hDEADBEEF);
      tick();

      // Register 0 ignores writes and never becomes busy
      drive(1'b1, 5'd0, 32'h1234, 5'd0, 5'd0, 1'b1, 5'd0);
      settle();
      tick();
      drive(1'b0, 5'd0, 32'h0, 5'd0, 5'd0, 1'b1, 5'd0);
      settle();
      check("r0_read", rd1_b | rd1_n, 32'h0);
      check("r0_isok", {30'b0, ok_b, ok_n}, 32'h3);
      tick();
      settle();
      check("r0_busy", {30'b0, busy1_b, busy1_n}, 32'h0);
      tick();

      // WAW stall on r3, then bypassed writeback re-grants issue
      drive(1'b0, 5'd0, 32'h0, 5'd3, 5'd0, 1'b1, 5'd3);
      settle();
      tick();
      settle();
      check("waw_stall", {30'b0, ok_b, ok_n}, 32'h0);
      check("waw_busy",  {30'b0, busy1_b, busy1_n}, 32'h3);
      tick();
      drive(1'b1, 5'd3, 32'h77, 5'd3, 5'd0, 1'b1, 5'd3);
      settle();
      check("wb_regrant", {30'b0, ok_b, ok_n}, 32'h2);
      tick();
      drive(1'b0, 5'd0, 32'h0, 5'd3, 5'd0, 1'b0, 5'd0);
      settle();
      check("r3_busy_after", {30'b0, busy1_b, busy1_n}, 32'h2);
      tick();

      // Issue and writeback to idle r9 in the same cycle
      drive(1'b1, 5'd9, 32'h55, 5'd0, 5'd0, 1'b1, 5'd9);
      settle();
      tick();
      drive(1'b0, 5'd0, 32'h0, 5'd9, 5'd9, 1'b0, 5'd0);
      settle();
      check("r9_busy", {30'b0, busy1_b, busy1_n}, 32'h3);
      check("r9_data", rd1_b & rd2_n, 32'h55);
      tick();

      // Async reset between edges clears data and busy
      drive(1'b1, 5'd4, 32'hA5, 5'd0, 5'd0, 1'b1, 5'd4);
      settle();
      tick();
      drive(1'b0, 5'd0, 32'h0, 5'd4, 5'd4, 1'b0, 5'd0);
      settle();
      check("r4_pre", rd1_b & rd1_n, 32'hA5);
      #1;
      rst_n = 1'b0;
      #1;
      check("arst_rd",   rd1_b | rd1_n, 32'h0);
      check("arst_busy", {30'b0, busy1_b, busy1_n}, 32'h0);
      model_reset();
      rst_n = 1'b1;
      tick();

      // Random traffic with addresses concentrated on a few registers to provoke hazards
      for (int n = 0; n < 400; n++) begin
         drive(1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), $urandom,
               5'($urandom_range(0, 7)), 5'($urandom_range(0, 31)),
               1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)));
         settle();
         tick();
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

`default_nettype wire
